// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, register-address width and the
// write-back entry record used by the load-result queue.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending load results. Entries can be invalidated in place
// by a newer write to the same register; the slot stays occupied until popped.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic [CNT_W-1:0]      count,
    input  logic                  inv_en,
    input  logic [REG_ADDR_W-1:0] inv_rd,
    input  logic [REG_ADDR_W-1:0] look_rd1,
    input  logic [REG_ADDR_W-1:0] look_rd2,
    output logic                  match1,
    output logic                  match2
);

    logic [DEPTH-1:0]      valid_reg;
    logic [REG_ADDR_W-1:0] rd_reg   [DEPTH];
    logic [XLEN-1:0]       data_reg [DEPTH];
    logic [PTR_W-1:0]      head_reg;
    logic [PTR_W-1:0]      tail_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [DEPTH-1:0]      hit1;
    logic [DEPTH-1:0]      hit2;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && tail_reg == PTR_W'(i)) begin
                    valid_reg[i] <= push_entry.valid;
                    rd_reg[i]    <= push_entry.rd;
                    data_reg[i]  <= push_entry.data;
                end else if ((pop && head_reg == PTR_W'(i)) ||
                             (inv_en && rd_reg[i] == inv_rd)) begin
                    valid_reg[i] <= 1'b0;
                end
            end
            if (push) tail_reg <= next_ptr(tail_reg);
            if (pop)  head_reg <= next_ptr(head_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lookup
            assign hit1[gi] = valid_reg[gi] && (rd_reg[gi] == look_rd1);
            assign hit2[gi] = valid_reg[gi] && (rd_reg[gi] == look_rd2);
        end
    endgenerate

    assign match1 = |hit1;
    assign match2 = |hit2;
    assign count  = count_reg;
    assign head   = '{valid: valid_reg[head_reg], rd: rd_reg[head_reg], data: data_reg[head_reg]};

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: ALU results beat queued loads, which beat
// a bypassing load. Also reports decode read hazards against pending writes.
module rf_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    input  logic [31:0]           rR1,
    input  logic [31:0]           rR2,
    output logic                  hz1,
    output logic                  hz2,
    output logic                  RFWr,
    output logic [31:0]           wR,
    output logic [XLEN-1:0]       wD
);

    localparam int CNT_W = $clog2(LQ_DEPTH + 1);

    logic [CNT_W-1:0]      count;
    wb_entry_t             head;
    wb_entry_t             push_entry;
    logic                  push;
    logic                  pop;
    logic                  ld_accept;
    logic                  q_nonempty;
    logic                  waw_drop;
    logic                  match1;
    logic                  match2;
    logic                  win_valid;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_data;
    logic                  wr_next;
    logic                  rf_wr_reg;
    logic [31:0]           wr_addr_reg;
    logic [XLEN-1:0]       wr_data_reg;

    assign ld_ready   = (count < CNT_W'(LQ_DEPTH));
    assign ld_accept  = ld_valid && ld_ready;
    assign q_nonempty = (count != '0);
    // A load colliding with an ALU write to the same register is already stale.
    assign waw_drop   = alu_valid && (alu_rd == ld_rd);
    assign push_entry = '{valid: 1'b1, rd: ld_rd, data: ld_data};

    always_comb begin
        pop       = 1'b0;
        win_valid = 1'b0;
        win_rd    = alu_rd;
        win_data  = alu_data;
        if (alu_valid) begin
            win_valid = 1'b1;
        end else if (q_nonempty) begin
            pop       = 1'b1;
            win_valid = head.valid;
            win_rd    = head.rd;
            win_data  = head.data;
        end else if (ld_accept) begin
            win_valid = 1'b1;
            win_rd    = ld_rd;
            win_data  = ld_data;
        end
        push    = ld_accept && !waw_drop && (alu_valid || q_nonempty);
        wr_next = win_valid && (win_rd != REG_ZERO);
    end

    wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .inv_en     (alu_valid),
        .inv_rd     (alu_rd),
        .look_rd1   (rR1[REG_ADDR_W-1:0]),
        .look_rd2   (rR2[REG_ADDR_W-1:0]),
        .match1     (match1),
        .match2     (match2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            rf_wr_reg <= wr_next;
            if (wr_next) begin
                wr_addr_reg <= {{(32-REG_ADDR_W){1'b0}}, win_rd};
                wr_data_reg <= win_data;
            end
        end
    end

    assign RFWr = rf_wr_reg;
    assign wR   = wr_addr_reg;
    assign wD   = wr_data_reg;

    assign hz1 = !rst && (rR1 != '0) && (rR1[31:REG_ADDR_W] == '0) &&
                 ((rf_wr_reg && wr_addr_reg == rR1) || match1);
    assign hz2 = !rst && (rR2 != '0) && (rR2[31:REG_ADDR_W] == '0) &&
                 ((rf_wr_reg && wr_addr_reg == rR2) || match2);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a per-cycle vector table for single-step
// behaviour plus hand-written full-queue and mid-operation reset sequences.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [31:0] rR1;
    logic [31:0] rR2;
    logic        hz1;
    logic        hz2;
    logic        RFWr;
    logic [31:0] wR;
    logic [31:0] wD;

    int tests;
    int failed;

    rf_wb_arbiter #(.LQ_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .rR1       (rR1),
        .rR2       (rR2),
        .hz1       (hz1),
        .hz2       (hz2),
        .RFWr      (RFWr),
        .wR        (wR),
        .wD        (wD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        e_wr;
        logic        chk_w;
        logic [31:0] e_wr_addr;
        logic [31:0] e_wd;
        logic        e_rdy;
        logic        e_h1;
        logic        e_h2;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic av, input logic [4:0] ard,
                          input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                          input logic [31:0] ldat, input logic [31:0] r1, input logic [31:0] r2);
        rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat; rR1 = r1; rR2 = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string nm, input logic [4:0] rd, input logic [31:0] d);
        chk({nm, ".RFWr"}, {31'b0, RFWr}, 32'd1);
        chk({nm, ".wR"}, wR, {27'b0, rd});
        chk({nm, ".wD"}, wD, d);
        $display("[TB] %s RFWr=%0b wR=%0d wD=0x%0h ld_ready=%0b", nm, RFWr, wR, wD, ld_ready);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

        //          rst av ard adat      lv lrd ldat      r1      r2     wr cw wR  wD        rdy h1 h2
        vecs[0]  = '{1, 0, 0,  32'h0,    0, 0,  32'h0,    0,      0,     0, 1, 0,  32'h0,    1, 0, 0};
        vecs[1]  = '{0, 1, 5,  32'h1234, 0, 0,  32'h0,    5,      6,     1, 1, 5,  32'h1234, 1, 1, 0};
        vecs[2]  = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    5,      0,     0, 1, 5,  32'h1234, 1, 0, 0};
        vecs[3]  = '{0, 1, 3,  32'h33,   1, 7,  32'hAA,   7,      3,     1, 1, 3,  32'h33,   1, 1, 1};
        vecs[4]  = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    7,      3,     1, 1, 7,  32'hAA,   1, 1, 0};
        vecs[5]  = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    7,      0,     0, 1, 7,  32'hAA,   1, 0, 0};
        vecs[6]  = '{0, 1, 1,  32'h01,   1, 4,  32'h11,   4,      0,     1, 1, 1,  32'h01,   1, 1, 0};
        vecs[7]  = '{0, 1, 4,  32'h22,   0, 0,  32'h0,    4,      0,     1, 1, 4,  32'h22,   1, 1, 0};
        vecs[8]  = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    4,      0,     0, 1, 4,  32'h22,   1, 0, 0};
        vecs[9]  = '{0, 1, 12, 32'hC1,   1, 12, 32'hC2,   12,     0,     1, 1, 12, 32'hC1,   1, 1, 0};
        vecs[10] = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    12,     0,     0, 1, 12, 32'hC1,   1, 0, 0};
        vecs[11] = '{0, 1, 0,  32'h55,   1, 0,  32'h66,   0,      0,     0, 0, 0,  32'h0,    1, 0, 0};
        vecs[12] = '{0, 0, 0,  32'h0,    1, 0,  32'h77,   0,      0,     0, 0, 0,  32'h0,    1, 0, 0};
        vecs[13] = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    0,      0,     0, 0, 0,  32'h0,    1, 0, 0};
        vecs[14] = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    0,      0,     0, 0, 0,  32'h0,    1, 0, 0};
        vecs[15] = '{0, 0, 0,  32'h0,    1, 9,  32'h99,   32'h29, 9,     1, 1, 9,  32'h99,   1, 0, 1};
        vecs[16] = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    0,      9,     0, 1, 9,  32'h99,   1, 0, 0};

        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].lv,
                   vecs[i].lrd, vecs[i].ldat, vecs[i].r1, vecs[i].r2);
            tick();
            chk($sformatf("vec%0d.RFWr", i), {31'b0, RFWr}, {31'b0, vecs[i].e_wr});
            if (vecs[i].chk_w) begin
                chk($sformatf("vec%0d.wR", i), wR, vecs[i].e_wr_addr);
                chk($sformatf("vec%0d.wD", i), wD, vecs[i].e_wd);
            end
            chk($sformatf("vec%0d.ld_ready", i), {31'b0, ld_ready}, {31'b0, vecs[i].e_rdy});
            chk($sformatf("vec%0d.hz1", i), {31'b0, hz1}, {31'b0, vecs[i].e_h1});
            chk($sformatf("vec%0d.hz2", i), {31'b0, hz2}, {31'b0, vecs[i].e_h2});
            $display("[TB] vec %0d RFWr=%0b wR=%0d wD=0x%0h ld_ready=%0b hz1=%0b hz2=%0b",
                     i, RFWr, wR, wD, ld_ready, hz1, hz2);
        end

        // Full queue: ALU busy every cycle while loads x8, x9, x10 arrive.
        set_in(0, 1, 20, 32'h200, 1, 8, 32'h80, 0, 0);
        chk("full.rdy0", {31'b0, ld_ready}, 32'd1);
        tick();
        chk_write("full.c0", 20, 32'h200);
        set_in(0, 1, 21, 32'h210, 1, 9, 32'h90, 0, 0);
        tick();
        chk_write("full.c1", 21, 32'h210);
        chk("full.rdy1", {31'b0, ld_ready}, 32'd0);
        set_in(0, 1, 22, 32'h220, 1, 10, 32'hA0, 0, 0);
        tick();
        chk_write("full.c2", 22, 32'h220);
        chk("full.rdy2", {31'b0, ld_ready}, 32'd0);
        set_in(0, 1, 23, 32'h230, 1, 10, 32'hA0, 0, 0);
        tick();
        chk_write("full.c3", 23, 32'h230);
        chk("full.rdy3", {31'b0, ld_ready}, 32'd0);
        set_in(0, 0, 0, 0, 1, 10, 32'hA0, 0, 0);
        tick();
        chk_write("full.c4", 8, 32'h80);
        chk("full.rdy4", {31'b0, ld_ready}, 32'd1);
        tick();
        chk_write("full.c5", 9, 32'h90);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_write("full.c6", 10, 32'hA0);
        tick();
        chk("full.c7.RFWr", {31'b0, RFWr}, 32'd0);

        // Reset with two loads still queued.
        set_in(0, 1, 1, 32'h1, 1, 14, 32'hE0, 0, 0);
        tick();
        set_in(0, 1, 2, 32'h2, 1, 15, 32'hF0, 14, 15);
        tick();
        chk("rst.pre.hz1", {31'b0, hz1}, 32'd1);
        chk("rst.pre.hz2", {31'b0, hz2}, 32'd1);
        chk("rst.pre.rdy", {31'b0, ld_ready}, 32'd0);
        set_in(1, 0, 0, 0, 0, 0, 0, 14, 15);
        #1;
        chk("rst.during.hz1", {31'b0, hz1}, 32'd0);
        chk("rst.during.hz2", {31'b0, hz2}, 32'd0);
        tick();
        chk("rst.after.RFWr", {31'b0, RFWr}, 32'd0);
        chk("rst.after.rdy", {31'b0, ld_ready}, 32'd1);
        chk("rst.after.wR", wR, 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 14, 15);
        #1;
        chk("rst.post.hz1", {31'b0, hz1}, 32'd0);
        chk("rst.post.hz2", {31'b0, hz2}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rst.idle%0d.RFWr", c), {31'b0, RFWr}, 32'd0);
            $display("[TB] rst idle %0d RFWr=%0b ld_ready=%0b", c, RFWr, ld_ready);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
